poly_add_seq: RTL
=================

# poly_add_seq

Sequencer for coefficient-wise modular addition of two polynomials. It streams up to N_COEF coefficient pairs out of two single-port coefficient memories, feeds each pair through one `mod_add` instance, and writes the reduced sums to a result memory. The block sits between the polynomial memories and the shared modular-arithmetic datapath, and is driven by a top-level start/done handshake.

## Interface
Parameters:
- N_COEF, 256, maximum coefficient count per operation
- ADDR_W, 8, coefficient address width; must satisfy 2^ADDR_W >= N_COEF

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_n_i  in  1  reset, asynchronous, active-low
- start_i  in  1  request; sampled only in IDLE
- len_i  in  ADDR_W+1  coefficient count; sampled with start_i
- q_i  in  23  modulus; sampled with start_i
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse
- rd_en_o  out  1  read strobe to both operand memories
- rd_addr_o  out  ADDR_W  read address, shared by both memories
- a_data_i  in  23  operand A coefficient; valid 1 cycle after rd_en_o
- b_data_i  in  23  operand B coefficient; valid 1 cycle after rd_en_o
- wr_en_o  out  1  result write strobe
- wr_addr_o  out  ADDR_W  result address
- wr_data_o  out  23  (a+b) mod q

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN on start_i=1. At that edge the block latches q_i and len_eff = min(len_i, N_COEF).
- IDLE to DONE instead if start_i=1 and len_i=0. No reads or writes are issued.
- RUN: issues one read per cycle at addresses 0..len_eff-1. Moves to DRAIN after the last read is issued.
- DRAIN: waits until the final write has been issued, then moves to DONE.
- DONE: done_o=1 for one cycle, then returns to IDLE.
- Datapath: a_data_i and b_data_i are zero-extended to 24 bits and fed to `mod_add` with the latched q. The 23-bit result is registered into wr_data_o.
- A 2-stage valid/address pipeline (read stage, then write stage) tracks outstanding coefficients. wr_addr_o equals the rd_addr_o that produced the data.
- Arithmetic contract: if a,b < q, then wr_data_o = a+b when a+b < q, otherwise a+b-q. Behaviour for operands >= q is not specified.
- start_i is ignored in RUN, DRAIN and DONE. Changes on q_i or len_i during an operation have no effect.
- Reset (rst_n_i=0) at any time, including mid-operation:
  - FSM goes to IDLE.
  - All outputs go to 0 immediately.
  - Pipeline valids clear, so no done pulse and no partial write follow.

## Timing
- Reset values: busy_o=0, done_o=0, rd_en_o=0, rd_addr_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0.
- Let T0 be the edge where start_i is accepted and L = len_eff.
- Reads: rd_en_o=1 with rd_addr_o=i during cycle T0+1+i, for i = 0..L-1.
- Writes: wr_en_o=1 with wr_addr_o=i and the matching wr_data_o during cycle T0+3+i.
- Last write falls in cycle T0+2+L. done_o pulses in cycle T0+3+L.
- busy_o=1 from cycle T0+1 through T0+2+L, and 0 during the done_o cycle.
- Throughput is 1 coefficient/cycle with no bubbles. Total latency from start to done is L+3 cycles.
- L=0: done_o pulses in cycle T0+1 and busy_o stays 0.
- Back-to-back operation: the earliest next start is accepted on the edge ending the done_o cycle's successor (IDLE). Every write from the previous operation has been issued before done_o.

## Test plan
- Reset: hold rst_n_i=0 for 3 cycles with start_i=1 -> all outputs 0. Release -> a start is accepted on the first IDLE edge.
- Directed sums, q=8380417, len=4, A={0,1,8380416,4190208}, B={0,8380416,8380416,4190209} -> writes addr0..3 = {0,0,8380415,0} in cycles T0+3..T0+6, done_o at T0+7.
- len_i=0 -> done_o pulses at T0+1; rd_en_o and wr_en_o never assert; busy_o stays 0.
- Full run, len_i=256, random A,B < q:
  - wr_addr_o steps 0..255 contiguously, and every result matches the reference modular sum.
  - done_o at T0+259.
  - start_i held high throughout causes no restart until IDLE.
  - len_i=300 behaves identically to len_i=256.
- Mid-run reset: assert rst_n_i asynchronously while wr_addr_o=10 -> outputs drop to 0 before the next edge and no done_o follows. A new start with len=4 then produces a clean, correct run.
- Modulus latch: start with q=17, A={16}, B={16}, len=1; drive q_i=8380417 after T0 -> wr_data_o=15 (the latched q is used).

Source files
------------

// File: rtl/poly_add_seq.sv
// Purpose : streams len_eff coefficient pairs from two operand memories through
//           one mod_add and writes (a+b) mod q to a result memory.
// Latency : L+3 cycles from accepted start to done_o; 1 coefficient/cycle.
// Backpressure: none; memories are assumed to answer 1 cycle after rd_en_o.
//
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   start_i, len_i, q_i       request, coefficient count, modulus (sampled in IDLE)
//   busy_o, done_o            status, one-cycle completion pulse
//   rd_en_o, rd_addr_o        shared read strobe/address for both operand memories
//   a_data_i, b_data_i        operand coefficients, valid 1 cycle after rd_en_o
//   wr_en_o, wr_addr_o, wr_data_o  result write port

module mod_add (
    input  logic [23:0] a,
    input  logic [23:0] b,
    input  logic [23:0] q,
    output logic [22:0] y
);
    logic [24:0] sum;
    logic [24:0] diff;
    logic [24:0] res;
    logic        unused_res_hi;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = sum - {1'b0, q};
    // Single conditional subtract is enough because a,b < q implies a+b < 2q.
    assign res  = (sum >= {1'b0, q}) ? diff : sum;
    assign y    = res[22:0];
    assign unused_res_hi = ^res[24:23];
endmodule

module poly_add_seq #(
    parameter int N_COEF = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   len_i,
    input  logic [22:0]       q_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [22:0]       a_data_i,
    input  logic [22:0]       b_data_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [22:0]       wr_data_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] N_COEF_W = (ADDR_W+1)'(N_COEF);

    state_t            state;
    logic [22:0]       q_lat;
    logic [ADDR_W-1:0] last_addr;

    // Read stage of the valid/address pipeline: marks the cycle in which
    // a_data_i/b_data_i carry the coefficient for s1_addr.
    logic              s1_vld;
    logic [ADDR_W-1:0] s1_addr;

    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W:0]   len_eff_m1;
    logic [22:0]       sum_mod;
    logic              unused_len_hi;

    assign len_eff    = (len_i > N_COEF_W) ? N_COEF_W : len_i;
    assign len_eff_m1 = len_eff - 1'b1;
    assign unused_len_hi = len_eff_m1[ADDR_W];

    mod_add u_mod_add (
        .a (({1'b0, a_data_i})),
        .b (({1'b0, b_data_i})),
        .q (({1'b0, q_lat})),
        .y (sum_mod)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            q_lat     <= '0;
            last_addr <= '0;
            s1_vld    <= 1'b0;
            s1_addr   <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
        end else begin
            s1_vld    <= rd_en_o;
            s1_addr   <= rd_addr_o;
            wr_en_o   <= s1_vld;
            wr_addr_o <= s1_addr;
            if (s1_vld) begin
                wr_data_o <= sum_mod;
            end

            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        q_lat     <= q_i;
                        last_addr <= len_eff_m1[ADDR_W-1:0];
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= RUN;
                            busy_o    <= 1'b1;
                            rd_en_o   <= 1'b1;
                            rd_addr_o <= '0;
                        end
                    end
                end
                RUN: begin
                    if (rd_addr_o == last_addr) begin
                        rd_en_o <= 1'b0;
                        state   <= DRAIN;
                    end else begin
                        rd_addr_o <= rd_addr_o + 1'b1;
                    end
                end
                DRAIN: begin
                    // Final write is on the bus once the read stage has emptied.
                    if (wr_en_o && !s1_vld) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
